// File: rtl/riscv_pipe_cpu.sv
// riscv_pipe_cpu: 5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with private
// instruction memory, register file and little-endian byte-addressed data memory.
module riscv_pipe_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_BYTES);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        a_zero;
        logic        link;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_dat;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        reg_we;
    } mem_wb_t;

    logic [31:0] pc_q, pc_d, imem_rdata, rf_rdata1, rf_rdata2;
    if_id_t      if_id, if_id_d;
    id_ex_t      id_ex, id_ex_d;
    ex_mem_t     ex_mem, ex_mem_d;
    mem_wb_t     mem_wb, mem_wb_d;
    logic [7:0]  dmem [0:DMEM_BYTES-1];

    pc_reg PC (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pc_d_i (pc_d),
        .pc_o   (pc_q)
    );

    instr_mem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
        .clk_i   (clk_i),
        .we_i    (1'b0),
        .addr_i  (pc_q[IAW+1:2]),
        .wdata_i (32'd0),
        .rdata_o (imem_rdata)
    );

    reg_file Registers (
        .clk_i    (clk_i),
        .we_i     (mem_wb.reg_we),
        .waddr_i  (mem_wb.rd),
        .wdata_i  (mem_wb.wdata),
        .raddr1_i (if_id.inst[19:15]),
        .raddr2_i (if_id.inst[24:20]),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // ---------------- ID: decode ----------------
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        legal, dec_reg_we, dec_mem_re, dec_mem_we, dec_use_imm, dec_a_zero, dec_link;
    logic        use_rs1, use_rs2, is_br, is_jal, is_jalr;
    alu_op_e     dec_alu;
    logic [31:0] dec_imm;

    assign opcode = if_id.inst[6:0];
    assign f3     = if_id.inst[14:12];
    assign f7     = if_id.inst[31:25];
    assign id_rs1 = if_id.inst[19:15];
    assign id_rs2 = if_id.inst[24:20];
    assign id_rd  = if_id.inst[11:7];

    always_comb begin
        legal = 1'b1;  dec_reg_we = 1'b0; dec_mem_re = 1'b0; dec_mem_we = 1'b0;
        dec_use_imm = 1'b0; dec_a_zero = 1'b0; dec_link = 1'b0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        dec_alu = ALU_ADD;
        dec_imm = {{20{if_id.inst[31]}}, if_id.inst[31:20]};
        case (opcode)
            7'b0110011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_reg_we = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: dec_alu = ALU_ADD;
                    {7'h20, 3'b000}: dec_alu = ALU_SUB;
                    {7'h00, 3'b001}: dec_alu = ALU_SLL;
                    {7'h00, 3'b010}: dec_alu = ALU_SLT;
                    {7'h00, 3'b011}: dec_alu = ALU_SLTU;
                    {7'h00, 3'b100}: dec_alu = ALU_XOR;
                    {7'h00, 3'b101}: dec_alu = ALU_SRL;
                    {7'h20, 3'b101}: dec_alu = ALU_SRA;
                    {7'h00, 3'b110}: dec_alu = ALU_OR;
                    {7'h00, 3'b111}: dec_alu = ALU_AND;
                    {7'h01, 3'b000}: dec_alu = ALU_MUL;
                    default:         legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                use_rs1 = 1'b1; dec_reg_we = 1'b1; dec_use_imm = 1'b1;
                case (f3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin dec_alu = ALU_SLL; legal = (f7 == 7'h00); end
                    default: begin
                        dec_alu = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        legal   = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            7'b0000011: begin
                use_rs1 = 1'b1; dec_reg_we = 1'b1; dec_mem_re = 1'b1; dec_use_imm = 1'b1;
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            7'b0100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_mem_we = 1'b1; dec_use_imm = 1'b1;
                dec_imm = {{20{if_id.inst[31]}}, if_id.inst[31:25], if_id.inst[11:7]};
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            7'b1100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_br = 1'b1;
                dec_imm = {{19{if_id.inst[31]}}, if_id.inst[31], if_id.inst[7],
                           if_id.inst[30:25], if_id.inst[11:8], 1'b0};
                legal = (f3 == 3'b000) || (f3 == 3'b001);
            end
            7'b1101111: begin
                is_jal = 1'b1; dec_reg_we = 1'b1; dec_link = 1'b1;
                dec_imm = {{11{if_id.inst[31]}}, if_id.inst[31], if_id.inst[19:12],
                           if_id.inst[20], if_id.inst[30:21], 1'b0};
            end
            7'b1100111: begin
                use_rs1 = 1'b1; is_jalr = 1'b1; dec_reg_we = 1'b1; dec_link = 1'b1;
                legal = (f3 == 3'b000);
            end
            7'b0110111: begin
                dec_reg_we = 1'b1; dec_a_zero = 1'b1; dec_use_imm = 1'b1;
                dec_imm = {if_id.inst[31:12], 12'd0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_reg_we = 1'b0; dec_mem_re = 1'b0; dec_mem_we = 1'b0;
            use_rs1 = 1'b0; use_rs2 = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        end
    end

    // ---------------- ID: hazards, branch resolution ----------------
    logic [31:0] id_rs1_fwd, id_rs2_fwd, br_target;
    logic        ex_hit, mem_ld_hit, stall, taken, redirect;

    always_comb begin
        id_rs1_fwd = rf_rdata1;
        if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_rs1)
            id_rs1_fwd = ex_mem.result;
        else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_rs1)
            id_rs1_fwd = mem_wb.wdata;
        id_rs2_fwd = rf_rdata2;
        if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_rs2)
            id_rs2_fwd = ex_mem.result;
        else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_rs2)
            id_rs2_fwd = mem_wb.wdata;
    end

    // Loads sitting in EX/MEM have no forwardable data yet, so branches wait them out.
    assign ex_hit     = id_ex.reg_we && id_ex.rd != 5'd0 &&
                        ((use_rs1 && id_ex.rd == id_rs1) || (use_rs2 && id_ex.rd == id_rs2));
    assign mem_ld_hit = ex_mem.mem_re && ex_mem.rd != 5'd0 &&
                        ((use_rs1 && ex_mem.rd == id_rs1) || (use_rs2 && ex_mem.rd == id_rs2));
    assign stall      = (ex_hit && (id_ex.mem_re || is_br || is_jalr)) ||
                        (mem_ld_hit && (is_br || is_jalr));
    assign taken      = (is_br && (f3[0] ? (id_rs1_fwd != id_rs2_fwd) : (id_rs1_fwd == id_rs2_fwd)))
                        || is_jal || is_jalr;
    assign br_target  = is_jalr ? ((id_rs1_fwd + dec_imm) & ~32'd1) : (if_id.pc + dec_imm);
    assign redirect   = taken && !stall;

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id;
        id_ex_d = '0;
        if (!stall) begin
            if (redirect) begin
                pc_d    = br_target;
                if_id_d = '0;
            end else if (start_i) begin
                pc_d         = pc_q + 32'd4;
                if_id_d.pc   = pc_q;
                if_id_d.inst = imem_rdata;
            end else begin
                if_id_d = '0;
            end
            id_ex_d.pc      = if_id.pc;
            id_ex_d.inst    = if_id.inst;
            id_ex_d.rs1     = id_rs1;
            id_ex_d.rs2     = id_rs2;
            id_ex_d.rd      = id_rd;
            id_ex_d.rs1_val = rf_rdata1;
            id_ex_d.rs2_val = rf_rdata2;
            id_ex_d.imm     = dec_imm;
            id_ex_d.alu_op  = dec_alu;
            id_ex_d.use_imm = dec_use_imm;
            id_ex_d.a_zero  = dec_a_zero;
            id_ex_d.link    = dec_link;
            id_ex_d.reg_we  = dec_reg_we;
            id_ex_d.mem_re  = dec_mem_re;
            id_ex_d.mem_we  = dec_mem_we;
            id_ex_d.funct3  = f3;
        end
    end

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;

    always_comb begin
        fwd_a = id_ex.rs1_val;
        if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
            fwd_a = ex_mem.result;
        else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
            fwd_a = mem_wb.wdata;
        fwd_b = id_ex.rs2_val;
        if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
            fwd_b = ex_mem.result;
        else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
            fwd_b = mem_wb.wdata;
    end

    assign op_a = id_ex.a_zero ? 32'd0 : fwd_a;
    assign op_b = id_ex.use_imm ? id_ex.imm : fwd_b;

    always_comb begin
        case (id_ex.alu_op)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << op_b[4:0];
            ALU_SRL:  alu_res = op_a >> op_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, op_a < op_b};
            ALU_MUL:  alu_res = op_a * op_b;
            default:  alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        ex_mem_d           = '0;
        ex_mem_d.inst      = id_ex.inst;
        ex_mem_d.rd        = id_ex.rd;
        ex_mem_d.result    = id_ex.link ? (id_ex.pc + 32'd4) : alu_res;
        ex_mem_d.store_dat = fwd_b;
        ex_mem_d.reg_we    = id_ex.reg_we;
        ex_mem_d.mem_re    = id_ex.mem_re;
        ex_mem_d.mem_we    = id_ex.mem_we;
        ex_mem_d.funct3    = id_ex.funct3;
    end

    // ---------------- MEM ----------------
    logic [DAW-3:0] mem_wa;
    logic [1:0]     mem_off;
    logic [31:0]    mem_word, mem_shifted, load_val, store_sh;
    logic [3:0]     store_be;

    assign mem_wa      = ex_mem.result[DAW-1:2];
    assign mem_off     = ex_mem.result[1:0];
    assign mem_word    = {dmem[{mem_wa, 2'd3}], dmem[{mem_wa, 2'd2}],
                          dmem[{mem_wa, 2'd1}], dmem[{mem_wa, 2'd0}]};
    assign mem_shifted = mem_word >> {mem_off, 3'b000};
    assign store_sh    = ex_mem.store_dat << {mem_off, 3'b000};

    always_comb begin
        case (ex_mem.funct3)
            3'b000:  load_val = {{24{mem_shifted[7]}}, mem_shifted[7:0]};
            3'b001:  load_val = {{16{mem_shifted[15]}}, mem_shifted[15:0]};
            3'b100:  load_val = {24'd0, mem_shifted[7:0]};
            3'b101:  load_val = {16'd0, mem_shifted[15:0]};
            default: load_val = mem_shifted;
        endcase
        case (ex_mem.funct3)
            3'b000:  store_be = 4'b0001 << mem_off;
            3'b001:  store_be = 4'b0011 << mem_off;
            default: store_be = 4'b1111;
        endcase
        mem_wb_d        = '0;
        mem_wb_d.inst   = ex_mem.inst;
        mem_wb_d.rd     = ex_mem.rd;
        mem_wb_d.reg_we = ex_mem.reg_we;
        mem_wb_d.wdata  = ex_mem.mem_re ? load_val : ex_mem.result;
    end

    always_ff @(posedge clk_i) begin
        if (ex_mem.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (store_be[i]) dmem[{mem_wa, 2'(i)}] <= store_sh[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if_id  <= if_id_d;
            id_ex  <= id_ex_d;
            ex_mem <= ex_mem_d;
            mem_wb <= mem_wb_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], ex_mem.result[31:DAW],
                           id_ex.inst, ex_mem.inst, mem_wb.inst};
endmodule

module pc_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_o <= 32'd0;
        else       pc_o <= pc_d_i;
    end
endmodule

module instr_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= wdata_i;
    end

    assign rdata_o = memory[addr_i];
endmodule

module reg_file (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != 5'd0) register[waddr_i] <= wdata_i;
    end

    // Same-cycle write-back is visible to the ID read.
    always_comb begin
        rdata1_o = register[raddr1_i];
        if (raddr1_i == 5'd0)                        rdata1_o = 32'd0;
        else if (we_i && waddr_i == raddr1_i)        rdata1_o = wdata_i;
        rdata2_o = register[raddr2_i];
        if (raddr2_i == 5'd0)                        rdata2_o = 32'd0;
        else if (we_i && waddr_i == raddr2_i)        rdata2_o = wdata_i;
    end
endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// Directed bench for riscv_pipe_cpu: preloads instruction memory, tracks PC cycle by
// cycle through a short program and checks architectural register/memory results.
module tb_riscv_pipe_cpu;
    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;
    int   checks   = 0;
    int   failures = 0;

    riscv_pipe_cpu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc [0:21];
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h18,
                   32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38,
                   32'h3C, 32'h40, 32'h44, 32'h50, 32'h54, 32'h58};

        rst_i   = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        repeat (2) @(negedge clk_i);

        check("reset_pc", dut.PC.pc_o, 32'd0);
        check("reset_if_id_inst", dut.if_id.inst, 32'd0);
        check("reset_id_ex_we", {31'd0, dut.id_ex.reg_we}, 32'd0);
        check("reset_ex_mem_we", {31'd0, dut.ex_mem.reg_we}, 32'd0);
        check("reset_mem_wb_rd", {27'd0, dut.mem_wb.rd}, 32'd0);

        rst_i = 1'b0;
        @(negedge clk_i);
        check("hold_pc_start_low", dut.PC.pc_o, 32'd0);

        // Empty memory: PC walks by 4, nothing is written.
        start_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("empty_pc_%0d", k), dut.PC.pc_o, 32'(4 * k));
            @(negedge clk_i);
        end
        repeat (6) @(negedge clk_i);
        for (int r = 0; r < 32; r++)
            check($sformatf("empty_x%0d", r), dut.Registers.register[r], 32'd0);

        // Program load under reset.
        rst_i   = 1'b1;
        start_i = 1'b0;
        dut.Instruction_Memory.memory[0]  = 32'h00500093; // addi x1,x0,5
        dut.Instruction_Memory.memory[1]  = 32'h00700113; // addi x2,x0,7
        dut.Instruction_Memory.memory[2]  = 32'h002081B3; // add  x3,x1,x2
        dut.Instruction_Memory.memory[3]  = 32'h00302023; // sw   x3,0(x0)
        dut.Instruction_Memory.memory[4]  = 32'h00002203; // lw   x4,0(x0)
        dut.Instruction_Memory.memory[5]  = 32'h004202B3; // add  x5,x4,x4
        dut.Instruction_Memory.memory[6]  = 32'hFFF00313; // addi x6,x0,-1
        dut.Instruction_Memory.memory[7]  = 32'h006001A3; // sb   x6,3(x0)
        dut.Instruction_Memory.memory[8]  = 32'h00000463; // beq  x0,x0,+8
        dut.Instruction_Memory.memory[9]  = 32'h00100493; // addi x9,x0,1 (flushed)
        dut.Instruction_Memory.memory[10] = 32'h00304383; // lbu  x7,3(x0)
        dut.Instruction_Memory.memory[11] = 32'h00300403; // lb   x8,3(x0)
        dut.Instruction_Memory.memory[16] = 32'h010000EF; // jal  x1,+16
        dut.Instruction_Memory.memory[17] = 32'h00100513; // addi x10,x0,1 (flushed)
        dut.Instruction_Memory.memory[18] = 32'h00100513; // skipped
        dut.Instruction_Memory.memory[19] = 32'h00100513; // skipped
        dut.Instruction_Memory.memory[20] = 32'h00900013; // addi x0,x0,9
        dut.Instruction_Memory.memory[21] = 32'h00300593; // addi x11,x0,3
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b1;

        for (int k = 0; k < 22; k++) begin
            check($sformatf("prog_pc_c%0d", k), dut.PC.pc_o, exp_pc[k]);
            if (k == 4) check("x1_before_wb", dut.Registers.register[1], 32'd0);
            if (k == 5) check("x1_after_wb", dut.Registers.register[1], 32'd5);
            if (k < 21) @(negedge clk_i);
        end

        start_i = 1'b0;
        @(negedge clk_i);
        check("freeze_pc_a", dut.PC.pc_o, 32'h58);
        @(negedge clk_i);
        check("freeze_pc_b", dut.PC.pc_o, 32'h58);
        repeat (10) @(negedge clk_i);

        check("x0",  dut.Registers.register[0],  32'd0);
        check("x1",  dut.Registers.register[1],  32'h44);
        check("x2",  dut.Registers.register[2],  32'd7);
        check("x3",  dut.Registers.register[3],  32'd12);
        check("x4",  dut.Registers.register[4],  32'd12);
        check("x5",  dut.Registers.register[5],  32'd24);
        check("x6",  dut.Registers.register[6],  32'hFFFFFFFF);
        check("x7",  dut.Registers.register[7],  32'd255);
        check("x8",  dut.Registers.register[8],  32'hFFFFFFFF);
        check("x9",  dut.Registers.register[9],  32'd0);
        check("x10", dut.Registers.register[10], 32'd0);
        check("x11", dut.Registers.register[11], 32'd3);
        check("dmem0", {24'd0, dut.dmem[0]}, 32'h0C);
        check("dmem3", {24'd0, dut.dmem[3]}, 32'hFF);
        check("freeze_pc_end", dut.PC.pc_o, 32'h58);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
